// File: rtl/led_step_tick_gen.sv
// Step-enable generator for the LED shift chain: selectable period timer plus
// debounced pause/resume and single-step buttons, all in the clk domain.
module led_step_tick_gen #(
  parameter int BASE_DIV  = 50_000_000,
  parameter int DB_CYCLES = 500_000,
  parameter int CNT_W     = 26,
  parameter int DB_W      = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed_sel,
  input  logic       btn_pause,
  input  logic       btn_step,
  output logic       step_en,
  output logic       running,
  output logic [7:0] step_count
);

  typedef enum logic {ST_RUN, ST_PAUSE} run_state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  run_state_t       state, state_nxt;
  logic [1:0]       btn_raw, sync1, sync2, stable, stable_d, press;
  logic [DB_W-1:0]  db_cnt [2];
  logic [CNT_W-1:0] cnt, cnt_nxt, per_last;
  logic [31:0]      per_full;
  logic [1:0]       spd_reg, spd_lat, spd_lat_nxt;
  logic             speed_chg, step_nxt, pause_evt, step_evt;
  logic [7:0]       count_nxt;

  assign btn_raw   = {btn_step, btn_pause};
  assign pause_evt = press[0];
  assign step_evt  = press[1];

  // Bit 0 is the pause button, bit 1 the step button; press is a registered rising edge of the debounced level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      press    <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            stable[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign per_full  = 32'(BASE_DIV) >> spd_lat;
  assign per_last  = CNT_W'(per_full - 32'd1);
  assign speed_chg = (spd_reg != spd_lat);

  // A speed change swallows any expiry in that cycle; resume beats a simultaneous step press
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    spd_lat_nxt = spd_lat;
    step_nxt    = 1'b0;
    if (speed_chg) begin
      spd_lat_nxt = spd_reg;
      cnt_nxt     = '0;
    end
    if (state == ST_RUN) begin
      if (!speed_chg) begin
        if (cnt == per_last) begin
          cnt_nxt  = '0;
          step_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      if (pause_evt) begin
        state_nxt = ST_PAUSE;
        cnt_nxt   = '0;
      end
    end else begin
      cnt_nxt = '0;
      if (pause_evt) state_nxt = ST_RUN;
      else if (step_evt) step_nxt = 1'b1;
    end
    if (step_en) step_nxt = 1'b0;
    count_nxt = step_nxt ? step_count + 8'd1 : step_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      cnt        <= '0;
      step_en    <= 1'b0;
      step_count <= '0;
      spd_reg    <= speed_sel;
      spd_lat    <= speed_sel;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      step_en    <= step_nxt;
      step_count <= count_nxt;
      spd_reg    <= speed_sel;
      spd_lat    <= spd_lat_nxt;
    end
  end

  assign running = (state == ST_RUN);

endmodule
